// File: rtl/keyflow_pkg.sv
// Shared KeyFlow constants and parser state encoding for the ingress label path.
package keyflow_pkg;

    localparam logic [15:0] KEYFLOW_ETHERTYPE     = 16'h88B5;
    localparam int          LABEL_BYTE_OFFSET     = 14;
    localparam int          ETHERTYPE_BYTE_OFFSET = 12;

    typedef enum logic [1:0] {
        PS_FIRST = 2'd0,
        PS_HDR   = 2'd1,
        PS_THRU  = 2'd2
    } parse_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream register slice; ingress ready is a flop that means "skid entry empty".
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] main_data_n;
    logic [WIDTH-1:0] skid_data_n;
    logic             skid_valid;
    logic             main_valid_n;
    logic             skid_valid_n;
    logic             accept;

    assign accept = s_valid & s_ready;

    always_comb begin
        main_valid_n = m_valid;
        main_data_n  = m_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        if (!m_valid || m_ready) begin
            // Skid entry drains first; ingress is closed whenever it is occupied.
            if (skid_valid) begin
                main_valid_n = 1'b1;
                main_data_n  = skid_data;
                skid_valid_n = 1'b0;
            end else begin
                main_valid_n = accept;
                if (accept) main_data_n = s_data;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_data_n  = s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_valid    <= 1'b0;
            skid_valid <= 1'b0;
            s_ready    <= 1'b0;
        end else begin
            m_valid    <= main_valid_n;
            skid_valid <= skid_valid_n;
            s_ready    <= ~skid_valid_n;
        end
    end

    always_ff @(posedge clk) begin
        m_data    <= main_data_n;
        skid_data <= skid_data_n;
    end

endmodule

// File: rtl/keyflow_label_parser.sv
// Forwards the packet stream through a skid buffer and emits one label pulse per packet,
// derived from the EtherType and route label observed on egress transfers.
module keyflow_label_parser #(
    parameter int          C_AXIS_DATA_WIDTH  = 64,
    parameter int          C_AXIS_TUSER_WIDTH = 128,
    parameter int          DIVIDER_WIDTH      = 16,
    parameter logic [15:0] KEYFLOW_ETHERTYPE  = keyflow_pkg::KEYFLOW_ETHERTYPE,
    parameter int          LABEL_BYTE_OFFSET  = keyflow_pkg::LABEL_BYTE_OFFSET
) (
    input  logic                            asclk,
    input  logic                            aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [DIVIDER_WIDTH-1:0]        dv_key,
    output logic                            action_req,
    output logic [31:0]                     num_keyflow_pkts,
    output logic [31:0]                     num_other_pkts
);

    localparam int         STRB_WIDTH    = C_AXIS_DATA_WIDTH / 8;
    localparam int         PAYLOAD_WIDTH = C_AXIS_TUSER_WIDTH + 1 + STRB_WIDTH + C_AXIS_DATA_WIDTH;
    localparam int         ETY_LANE      = keyflow_pkg::ETHERTYPE_BYTE_OFFSET % 8;
    localparam logic [3:0] ETY_BEAT      = 4'(keyflow_pkg::ETHERTYPE_BYTE_OFFSET / 8);
    localparam int         LABEL_LANE    = LABEL_BYTE_OFFSET % 8;
    localparam logic [3:0] LABEL_BEAT    = 4'(LABEL_BYTE_OFFSET / 8);

    if (C_AXIS_DATA_WIDTH != 64 || DIVIDER_WIDTH != 16 || LABEL_LANE > 6) begin : g_param_check
        $error("keyflow_label_parser: unsupported parameter set");
    end

    axis_skid_buffer #(
        .WIDTH(PAYLOAD_WIDTH)
    ) u_skid (
        .clk    (asclk),
        .resetn (aresetn),
        .s_data ({s_axis_tuser, s_axis_tlast, s_axis_tstrb, s_axis_tdata}),
        .s_valid(s_axis_tvalid),
        .s_ready(s_axis_tready),
        .m_data ({m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata}),
        .m_valid(m_axis_tvalid),
        .m_ready(m_axis_tready)
    );

    keyflow_pkg::parse_state_t state, state_n;
    logic [3:0]               beat_cnt;
    logic                     ety_ok;
    logic                     ety_now;
    logic                     ety_eff;
    logic                     label_strb_ok;
    logic [15:0]              label_now;
    logic                     xfer;
    logic                     pulse_n;
    logic                     good_n;
    logic [DIVIDER_WIDTH-1:0] key_n;

    assign xfer          = m_axis_tvalid & m_axis_tready;
    assign ety_now       = ({m_axis_tdata[8*ETY_LANE +: 8], m_axis_tdata[8*(ETY_LANE+1) +: 8]} == KEYFLOW_ETHERTYPE)
                           && (m_axis_tstrb[ETY_LANE +: 2] == 2'b11);
    // The EtherType and label may share a beat, so use the live compare on that beat.
    assign ety_eff       = (beat_cnt == ETY_BEAT) ? ety_now : ety_ok;
    assign label_now     = {m_axis_tdata[8*LABEL_LANE +: 8], m_axis_tdata[8*(LABEL_LANE+1) +: 8]};
    assign label_strb_ok = &m_axis_tstrb[LABEL_LANE +: 2];

    always_comb begin
        state_n = state;
        pulse_n = 1'b0;
        good_n  = 1'b0;
        key_n   = dv_key;
        case (state)
            keyflow_pkg::PS_FIRST: begin
                if (xfer) begin
                    if (m_axis_tlast) begin
                        pulse_n = 1'b1;
                        key_n   = '0;
                    end else begin
                        state_n = keyflow_pkg::PS_HDR;
                    end
                end
            end
            keyflow_pkg::PS_HDR: begin
                if (xfer) begin
                    if (beat_cnt == LABEL_BEAT) begin
                        pulse_n = 1'b1;
                        if (ety_eff && label_strb_ok) begin
                            key_n  = DIVIDER_WIDTH'(label_now);
                            good_n = 1'b1;
                        end else begin
                            key_n = '0;
                        end
                        state_n = m_axis_tlast ? keyflow_pkg::PS_FIRST : keyflow_pkg::PS_THRU;
                    end else if (m_axis_tlast) begin
                        pulse_n = 1'b1;
                        key_n   = '0;
                        state_n = keyflow_pkg::PS_FIRST;
                    end
                end
            end
            keyflow_pkg::PS_THRU: begin
                if (xfer && m_axis_tlast) state_n = keyflow_pkg::PS_FIRST;
            end
            default: state_n = keyflow_pkg::PS_FIRST;
        endcase
    end

    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            state            <= keyflow_pkg::PS_FIRST;
            beat_cnt         <= '0;
            ety_ok           <= 1'b0;
            action_req       <= 1'b0;
            dv_key           <= '0;
            num_keyflow_pkts <= '0;
            num_other_pkts   <= '0;
        end else begin
            state      <= state_n;
            action_req <= pulse_n;
            dv_key     <= key_n;
            if (pulse_n) begin
                if (good_n) num_keyflow_pkts <= num_keyflow_pkts + 32'd1;
                else        num_other_pkts   <= num_other_pkts + 32'd1;
            end
            if (xfer) begin
                if (m_axis_tlast) begin
                    beat_cnt <= '0;
                    ety_ok   <= 1'b0;
                end else begin
                    if (beat_cnt != 4'd15)     beat_cnt <= beat_cnt + 4'd1;
                    if (beat_cnt == ETY_BEAT)  ety_ok   <= ety_now;
                end
            end
        end
    end

endmodule

// File: doc/keyflow_label_parser.md
# keyflow_label_parser

Ingress stage placed directly upstream of `keyflow_processor` in `openflow_datapath`. It forwards the packet AXI stream through a registered skid buffer. While forwarding, it extracts the 16-bit KeyFlow route label from the header and emits exactly one `action_req` pulse per packet, with the label on `dv_key`, in packet order. Packets that are not KeyFlow, or that are too short to carry a label, still get a pulse, but with label 0, which the downstream remainder logic maps to drop.

## Interface
Parameters:
- `C_AXIS_DATA_WIDTH`, 64: stream data width; only 64 is supported.
- `C_AXIS_TUSER_WIDTH`, 128: tuser width; tuser is passed through unmodified.
- `DIVIDER_WIDTH`, 16: label width; must be 16.
- `KEYFLOW_ETHERTYPE`, 16'h88B5: EtherType that marks a KeyFlow packet, at bytes 12–13.
- `LABEL_BYTE_OFFSET`, 14: byte offset of the label's MSB. `LABEL_BYTE_OFFSET % 8` must be ≤ 6 so the label sits in a single beat; otherwise elaboration fails.

Ports (reset aresetn, synchronous, active-low; clock asclk):
- `asclk`, in, 1: clock.
- `aresetn`, in, 1: synchronous active-low reset.
- `s_axis_tdata` / `tstrb` / `tuser` / `tvalid` / `tlast`, in, 64 / 8 / 128 / 1 / 1: ingress stream.
- `s_axis_tready`, out, 1: ingress ready; equals "skid buffer not full".
- `m_axis_tdata` / `tstrb` / `tuser` / `tvalid` / `tlast`, out, 64 / 8 / 128 / 1 / 1: egress stream.
- `m_axis_tready`, in, 1: egress ready.
- `dv_key`, out, 16: label; held stable until the next pulse.
- `action_req`, out, 1: one-cycle pulse, one per packet.
- `num_keyflow_pkts`, out, 32: count of packets with a matching EtherType and a label present.
- `num_other_pkts`, out, 32: count of packets sent with label 0.

## Operation
- Byte lane `n` of a beat is `tdata[8n+7:8n]`; lane 0 is the earliest byte. Multi-byte fields are big-endian.
- Parsing observes egress transfers only (`m_axis_tvalid & m_axis_tready`), so each pulse follows the beat it describes.
- Beat counter `beat_cnt` (4 bits) counts transfers within a packet and saturates at 15.
- State machine:
  - **PS_FIRST**: transfer of beat 0 → PS_HDR. If that beat has `tlast`, emit a label-0 pulse and stay in PS_FIRST.
  - **PS_HDR**:
    - On transfer of beat 1, latch `ety_ok` = ({lane4, lane5} == `KEYFLOW_ETHERTYPE`, and `tstrb[5:4]` == 2'b11).
    - On transfer of label beat `LABEL_BYTE_OFFSET/8`:
      - If `ety_ok` and both label lane strobes are set, capture {lane L, lane L+1} with L = `LABEL_BYTE_OFFSET % 8`, and mark the packet good.
      - Otherwise capture 0.
      - Then → PS_THRU, or → PS_FIRST if that beat has `tlast`.
    - `tlast` before the label beat → label-0 pulse, → PS_FIRST.
  - **PS_THRU**: `tlast` transfer → PS_FIRST; no pulse.
- Pulse generation:
  - The pulse is registered: `action_req`=1 and `dv_key` updated on the clock edge after the deciding transfer.
  - Good packets increment `num_keyflow_pkts`; label-0 packets increment `num_other_pkts`.
  - Counters wrap at 2^32.
- Every packet produces exactly one pulse, including runts and non-KeyFlow traffic, so downstream metadata ordering is preserved.
- Data, strobe, tuser and last pass through bit-exact.

## Timing
- Reset values: `m_axis_tvalid`=0, `s_axis_tready`=0 during reset and 1 on the first cycle after, `action_req`=0, `dv_key`=0, both counters 0, state PS_FIRST, `beat_cnt`=0.
- Data latency: 1 cycle from `s_axis` acceptance to `m_axis_tvalid`.
- Throughput: full rate, one beat per cycle, when `m_axis_tready` is held high.
- Backpressure:
  - A 2-entry skid buffer keeps `s_axis_tready` registered.
  - With `m_axis_tready`=0, at most 2 beats are absorbed before `s_axis_tready` drops.
  - `m_axis_*` stay stable while `m_axis_tvalid` is high and `m_axis_tready` is low.
- `action_req` latency: exactly 1 cycle after the deciding egress transfer. Pulses never overlap; the minimum spacing is 1 cycle, for back-to-back 1-beat packets.
- A label beat that also carries `tlast` produces one pulse only.
- Reset mid-packet flushes the skid buffer and abandons the partial packet with no pulse. The parser resynchronises on the next beat, which is treated as beat 0.

## Structure
- Shared package `keyflow_pkg`: `KEYFLOW_ETHERTYPE`, the default `LABEL_BYTE_OFFSET`, the ETHERTYPE byte offset (12), and the state encodings PS_FIRST / PS_HDR / PS_THRU.
- One sub-module: `axis_skid_buffer`, a 2-entry register slice parameterised on the concatenated {tuser, tlast, tstrb, tdata} width. The parser is the FSM plus the counters around it.

## Test plan
- KeyFlow packet with bytes 12–13 = 88 B5 and bytes 14–15 = 00 0B, 4 beats → one pulse with `dv_key`=16'h000B, 1 cycle after the beat-1 egress transfer; `num_keyflow_pkts`=1; egress data identical to ingress.
- IPv4 packet with EtherType 0800, 8 beats → one pulse with `dv_key`=0; `num_other_pkts`=1.
- Single-beat runt with `tlast` on beat 0 → pulse with `dv_key`=0 on the cycle after that transfer.
- 3 back-to-back KeyFlow packets with labels 7, 12, 19, while `m_axis_tready` toggles 1010… → pulses in order 7, 12, 19; no beat lost or duplicated; `s_axis_tready` falls within 2 beats of a stall.
- Label beat with `tstrb`=8'h3F (label lanes invalid) → `dv_key`=0, counted in `num_other_pkts`.
- `aresetn` asserted mid-packet at beat 2, then a clean packet with label 5 → no pulse for the partial packet; the next pulse has `dv_key`=5 and the counters read 0 before it.
